// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, ALU flags, memory handshake and datapath control bundle
// for the multicycle control unit.
interface multicycle_control_unit_if #(
  parameter int unsigned REG_SEL_W = 2
);
  localparam int unsigned OPCODE_W = 23 + 2 * REG_SEL_W;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [3:0]           flags;
  logic                 dmem_ready;

  logic                 imem_we;
  logic                 pc_mux;
  logic                 pc_we;
  logic [REG_SEL_W-1:0] reg_port0_sel;
  logic [REG_SEL_W-1:0] reg_port1_sel;
  logic [REG_SEL_W-1:0] reg_write_sel;
  logic                 reg_write_en;
  logic                 alu_src_mux;
  logic [1:0]           alu_select;
  logic                 flag_write_en;
  logic                 alu_result_mux;
  logic                 dmem_input_mux;
  logic                 dmem_write_en;
  logic                 dmem_read_en;
  logic                 reg_writeback_mux;

  logic [4:0]           opi_o;
  logic                 illegal_op;
  logic                 mem_fault;
  logic [2:0]           state_o;

  modport master (
    output instr_valid, opcode, flags, dmem_ready,
    input  instr_ready, imem_we, pc_mux, pc_we, reg_port0_sel, reg_port1_sel,
           reg_write_sel, reg_write_en, alu_src_mux, alu_select, flag_write_en,
           alu_result_mux, dmem_input_mux, dmem_write_en, dmem_read_en,
           reg_writeback_mux, opi_o, illegal_op, mem_fault, state_o
  );

  modport slave (
    input  instr_valid, opcode, flags, dmem_ready,
    output instr_ready, imem_we, pc_mux, pc_we, reg_port0_sel, reg_port1_sel,
           reg_write_sel, reg_write_en, alu_src_mux, alu_select, flag_write_en,
           alu_result_mux, dmem_input_mux, dmem_write_en, dmem_read_en,
           reg_writeback_mux, opi_o, illegal_op, mem_fault, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: one-hot opcode decode, IDLE/EXEC/MEM/WB sequencing,
// branch resolution and bounded data-memory wait with fault skip.
module multicycle_control_unit #(
  parameter int unsigned REG_SEL_W   = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.slave bus
);
  localparam int unsigned OP_W  = 23;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {IDLE = 3'd0, EXEC = 3'd1, MEM = 3'd2, WB = 3'd3} state_e;

  localparam logic [4:0] OP_INPUTC = 5'd1,  OP_INPUTCF = 5'd2,  OP_INPUTD = 5'd3;
  localparam logic [4:0] OP_INPUTDF = 5'd4, OP_MOVE = 5'd5,     OP_LOADI = 5'd6;
  localparam logic [4:0] OP_ADD = 5'd7,     OP_ADDI = 5'd8,     OP_SUB = 5'd9;
  localparam logic [4:0] OP_SUBI = 5'd10,   OP_LOAD = 5'd11,    OP_LOADF = 5'd12;
  localparam logic [4:0] OP_STORE = 5'd13,  OP_STOREF = 5'd14,  OP_SHIFTL = 5'd15;
  localparam logic [4:0] OP_SHIFTR = 5'd16, OP_CMP = 5'd17,     OP_JUMP = 5'd18;
  localparam logic [4:0] OP_BRE = 5'd19,    OP_BRNE = 5'd20,    OP_BRG = 5'd21;
  localparam logic [4:0] OP_BRGE = 5'd22;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [4:0]           opi_q, opi_d;
  logic [REG_SEL_W-1:0] x_q, x_d, y_q, y_d;
  logic                 illegal_q, illegal_d;

  logic [OP_W-1:0]      op_field;
  logic [4:0]           dec_opi;
  logic                 dec_seen, dec_multi;

  logic                 is_mem, is_load, is_wb, is_flag, is_imem, br_take;
  logic [REG_SEL_W-1:0] sel0, sel1;
  logic [1:0]           alu_sel;
  logic                 src_imm, res_sel, din_sel, wb_sel;
  logic                 z_flag, ge_flag, active;
  logic                 unused_flag;

  logic pc_we_c, pc_mux_c, flag_we_c, imem_we_c, reg_we_c, dmem_we_c, dmem_re_c;
  logic mem_fault_c, ready_c;

  assign op_field    = bus.opcode[OP_W-1:0];
  assign z_flag      = bus.flags[0];
  assign ge_flag     = ~(bus.flags[1] ^ bus.flags[2]);
  assign unused_flag = bus.flags[3];
  assign active      = (state_q != IDLE);

  // Incoming op field to index; any multi-hot field collapses to NOOP.
  always_comb begin
    dec_opi   = '0;
    dec_seen  = 1'b0;
    dec_multi = 1'b0;
    for (int k = 0; k < int'(OP_W); k++) begin
      if (op_field[k]) begin
        dec_multi = dec_multi | dec_seen;
        dec_seen  = 1'b1;
        dec_opi   = 5'(k + 1);
      end
    end
    if (dec_multi) dec_opi = '0;
  end

  // Per-op datapath controls and classification from the registered op.
  always_comb begin
    is_mem  = 1'b0;
    is_load = 1'b0;
    is_wb   = 1'b0;
    is_flag = 1'b0;
    is_imem = 1'b0;
    br_take = 1'b0;
    sel0    = '0;
    sel1    = '0;
    alu_sel = 2'b00;
    src_imm = 1'b0;
    res_sel = 1'b0;
    din_sel = 1'b0;
    wb_sel  = 1'b0;
    case (opi_q)
      OP_INPUTC:  begin is_imem = 1'b1; res_sel = 1'b1; end
      OP_INPUTCF: begin is_imem = 1'b1; sel0 = x_q; alu_sel = 2'b10; src_imm = 1'b1; end
      OP_INPUTD:  begin is_mem = 1'b1; res_sel = 1'b1; din_sel = 1'b1; end
      OP_INPUTDF: begin is_mem = 1'b1; sel0 = x_q; alu_sel = 2'b10; src_imm = 1'b1; din_sel = 1'b1; end
      OP_MOVE:    begin is_wb = 1'b1; sel0 = y_q; alu_sel = 2'b10; end
      OP_LOADI:   begin is_wb = 1'b1; res_sel = 1'b1; end
      OP_ADD:     begin is_wb = 1'b1; is_flag = 1'b1; sel0 = x_q; sel1 = y_q; alu_sel = 2'b10; end
      OP_ADDI:    begin is_wb = 1'b1; is_flag = 1'b1; sel0 = x_q; alu_sel = 2'b10; src_imm = 1'b1; end
      OP_SUB:     begin is_wb = 1'b1; is_flag = 1'b1; sel0 = x_q; sel1 = y_q; alu_sel = 2'b11; end
      OP_SUBI:    begin is_wb = 1'b1; is_flag = 1'b1; sel0 = x_q; alu_sel = 2'b11; src_imm = 1'b1; end
      OP_LOAD:    begin is_mem = 1'b1; is_load = 1'b1; res_sel = 1'b1; wb_sel = 1'b1; end
      OP_LOADF:   begin is_mem = 1'b1; is_load = 1'b1; sel0 = y_q; alu_sel = 2'b10; src_imm = 1'b1; wb_sel = 1'b1; end
      OP_STORE:   begin is_mem = 1'b1; sel1 = x_q; end
      OP_STOREF:  begin is_mem = 1'b1; sel0 = y_q; sel1 = x_q; alu_sel = 2'b10; src_imm = 1'b1; end
      OP_SHIFTL:  begin is_wb = 1'b1; is_flag = 1'b1; sel0 = x_q; end
      OP_SHIFTR:  begin is_wb = 1'b1; is_flag = 1'b1; sel0 = x_q; alu_sel = 2'b01; end
      OP_CMP:     begin is_flag = 1'b1; sel0 = x_q; sel1 = y_q; alu_sel = 2'b11; end
      OP_JUMP:    br_take = 1'b1;
      OP_BRE:     br_take = z_flag;
      OP_BRNE:    br_take = ~z_flag;
      OP_BRG:     br_take = ~z_flag & ge_flag;
      OP_BRGE:    br_take = ge_flag;
      default:    ;
    endcase
  end

  // Next state and per-cycle strobes.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    opi_d       = opi_q;
    x_d         = x_q;
    y_d         = y_q;
    illegal_d   = 1'b0;
    ready_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_mux_c    = 1'b0;
    flag_we_c   = 1'b0;
    imem_we_c   = 1'b0;
    reg_we_c    = 1'b0;
    dmem_we_c   = 1'b0;
    dmem_re_c   = 1'b0;
    mem_fault_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) begin
          opi_d     = dec_opi;
          y_d       = bus.opcode[OP_W +: REG_SEL_W];
          x_d       = bus.opcode[OP_W + REG_SEL_W +: REG_SEL_W];
          illegal_d = dec_multi;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        flag_we_c = is_flag;
        imem_we_c = is_imem;
        pc_mux_c  = br_take;
        if (is_mem) begin
          wait_d  = '0;
          state_d = MEM;
        end else if (is_wb) begin
          state_d = WB;
        end else begin
          pc_we_c = 1'b1;
          state_d = IDLE;
        end
      end
      MEM: begin
        dmem_we_c = ~is_load;
        dmem_re_c = is_load;
        if (bus.dmem_ready) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            pc_we_c = 1'b1;
            state_d = IDLE;
          end
        end else if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // Give up on the access: skip the instruction without a register write.
          mem_fault_c = 1'b1;
          pc_we_c     = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      opi_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opi_q     <= opi_d;
      x_q       <= x_d;
      y_q       <= y_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.instr_ready       = ready_c;
  assign bus.pc_we             = pc_we_c;
  assign bus.pc_mux            = pc_mux_c;
  assign bus.flag_write_en     = flag_we_c;
  assign bus.imem_we           = imem_we_c;
  assign bus.reg_write_en      = reg_we_c;
  assign bus.dmem_write_en     = dmem_we_c;
  assign bus.dmem_read_en      = dmem_re_c;
  assign bus.mem_fault         = mem_fault_c;
  assign bus.illegal_op        = illegal_q;
  assign bus.state_o           = state_q;
  assign bus.opi_o             = active ? opi_q : '0;
  assign bus.reg_port0_sel     = active ? sel0 : '0;
  assign bus.reg_port1_sel     = active ? sel1 : '0;
  assign bus.reg_write_sel     = (active && (is_wb || is_load)) ? x_q : '0;
  assign bus.alu_select        = active ? alu_sel : 2'b00;
  assign bus.alu_src_mux       = active & src_imm;
  assign bus.alu_result_mux    = active & res_sel;
  assign bus.dmem_input_mux    = active & din_sel;
  assign bus.reg_writeback_mux = active & wb_sel;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle comparison against a
// phase-level instruction model, plus directed literal checks.
module tb_multicycle_control_unit;
  localparam int unsigned R  = 2;
  localparam int          TO = 15;

  typedef struct packed {
    logic [2:0] st;
    logic rdy, pcwe, pcmux, fwe, imwe, rwe, dwe, dre, fault, ill;
    logic [4:0] opi;
    logic [1:0] p0, p1, ws, alu;
    logic src, res, din, wbm;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_control_unit_if #(.REG_SEL_W(R)) bus ();
  multicycle_control_unit #(.REG_SEL_W(R), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t trace[$];
  obs_t post;

  function automatic obs_t snap();
    obs_t a;
    a.st = bus.state_o;        a.rdy = bus.instr_ready;   a.pcwe = bus.pc_we;
    a.pcmux = bus.pc_mux;      a.fwe = bus.flag_write_en; a.imwe = bus.imem_we;
    a.rwe = bus.reg_write_en;  a.dwe = bus.dmem_write_en; a.dre = bus.dmem_read_en;
    a.fault = bus.mem_fault;   a.ill = bus.illegal_op;    a.opi = bus.opi_o;
    a.p0 = bus.reg_port0_sel;  a.p1 = bus.reg_port1_sel;  a.ws = bus.reg_write_sel;
    a.alu = bus.alu_select;    a.src = bus.alu_src_mux;   a.res = bus.alu_result_mux;
    a.din = bus.dmem_input_mux; a.wbm = bus.reg_writeback_mux;
    return a;
  endfunction

  // Single compare process: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = snap();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic int field_opi(input logic [22:0] f);
    if ($countones(f) != 1) return 0;
    for (int k = 0; k < 23; k++) if (f[k]) return k + 1;
    return 0;
  endfunction

  function automatic logic [22:0] fld(input int opi);
    logic [22:0] one;
    one = 23'd1;
    return (opi == 0) ? 23'd0 : (one << (opi - 1));
  endfunction

  // 0 = retire from EXEC, 1 = via WB, 2 = via MEM
  function automatic int op_kind(input int opi);
    if (opi inside {3, 4, 11, 12, 13, 14}) return 2;
    if (opi inside {5, 6, 7, 8, 9, 10, 15, 16}) return 1;
    return 0;
  endfunction

  function automatic logic branch(input int opi, input logic [3:0] f);
    logic z, ge;
    z  = f[0];
    ge = (f[1] == f[2]);
    case (opi)
      18: return 1'b1;
      19: return z;
      20: return !z;
      21: return !z && ge;
      22: return ge;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t idle_obs();
    obs_t e;
    e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  function automatic obs_t busy(input int opi, input logic [1:0] x, input logic [1:0] y, input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st  = st;
    e.opi = 5'(opi);
    if (opi inside {7, 9, 17}) begin e.p0 = x; e.p1 = y; end
    if (opi inside {8, 10, 15, 16, 2, 4}) e.p0 = x;
    if (opi inside {5, 12, 14}) e.p0 = y;
    if (opi inside {13, 14}) e.p1 = x;
    if (opi inside {5, 6, 7, 8, 9, 10, 15, 16, 11, 12}) e.ws = x;
    if (opi inside {7, 8, 5, 12, 14, 2, 4}) e.alu = 2'b10;
    else if (opi inside {9, 10, 17}) e.alu = 2'b11;
    else if (opi == 16) e.alu = 2'b01;
    e.src = opi inside {8, 10, 12, 14, 2, 4};
    e.res = opi inside {1, 3, 6, 11};
    e.din = opi inside {3, 4};
    e.wbm = opi inside {11, 12};
    return e;
  endfunction

  // ---- driver ----
  task automatic cyc(input obs_t e, input string tag, input bit keep);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    if (keep) trace.push_back(snap());
    else post = snap();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [22:0] field, input logic [1:0] x, input logic [1:0] y,
                           input logic [3:0] fl, input int ready_at, input int rst_at);
    int opi, kind;
    bit load, to_wb, fin;
    obs_t e;
    logic [26:0] opc;
    opi  = field_opi(field);
    kind = op_kind(opi);
    load = opi inside {11, 12};
    opc  = {x, y, field};
    trace.delete();
    bus.instr_valid = 1'b1; bus.opcode = opc; bus.flags = ~fl; bus.dmem_ready = 1'b1;
    cyc(idle_obs(), "handshake", 1'b1);
    adv();
    bus.instr_valid = 1'b0; bus.opcode = ~opc; bus.flags = fl;
    e = busy(opi, x, y, 3'd1);
    e.fwe   = opi inside {7, 8, 9, 10, 15, 16, 17};
    e.imwe  = opi inside {1, 2};
    e.pcmux = branch(opi, fl);
    e.ill   = ($countones(field) > 1);
    e.pcwe  = (kind == 0);
    cyc(e, "exec", 1'b1);
    adv();
    to_wb = (kind == 1);
    if (kind == 2) begin
      for (int m = 1; m <= TO; m++) begin
        fin = 1'b0;
        bus.dmem_ready = (m == ready_at);
        rst = (m == rst_at);
        e = busy(opi, x, y, 3'd2);
        e.dwe = !load;
        e.dre = load;
        if (m == ready_at) begin
          fin = 1'b1;
          if (load) to_wb = 1'b1;
          else e.pcwe = 1'b1;
        end else if (m == TO) begin
          fin = 1'b1;
          e.fault = 1'b1;
          e.pcwe = 1'b1;
        end
        cyc(e, "mem", 1'b1);
        adv();
        if (rst) begin
          rst = 1'b0;
          to_wb = 1'b0;
          fin = 1'b1;
        end
        if (fin) break;
      end
    end
    if (to_wb) begin
      bus.dmem_ready = 1'b0;
      e = busy(opi, x, y, 3'd3);
      e.rwe = 1'b1;
      e.pcwe = 1'b1;
      cyc(e, "wb", 1'b1);
      adv();
    end
    bus.dmem_ready = 1'b1; bus.opcode = '0;
    cyc(idle_obs(), "post_idle", 1'b0);
    adv();
  endtask

  function automatic int count_field(input int which);
    int n;
    n = 0;
    foreach (trace[i]) begin
      case (which)
        0: n += int'(trace[i].pcwe);
        1: n += int'(trace[i].dre);
        default: n += int'(trace[i].dwe);
      endcase
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    bus.instr_valid = 1'b0; bus.opcode = '0; bus.flags = '0; bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(idle_obs(), "reset_idle", 1'b0);
    chk("reset_ready", int'(bus.instr_ready), 1);
    chk("reset_state", int'(bus.state_o), 0);
    adv();

    // ADD x=1 y=2
    run_instr(fld(7), 2'd1, 2'd2, 4'b0000, 0, 0);
    chk("add_len", trace.size(), 3);
    chk("add_flag_we", int'(trace[1].fwe), 1);
    chk("add_wb_we", int'(trace[2].rwe), 1);
    chk("add_wsel", int'(trace[2].ws), 1);
    chk("add_wb_pcwe", int'(trace[2].pcwe), 1);
    chk("add_pcwe_once", count_field(0), 1);

    // BRNE not-equal then equal
    run_instr(fld(20), 2'd0, 2'd0, 4'b0000, 0, 0);
    chk("brne_z0_len", trace.size(), 2);
    chk("brne_z0_mux", int'(trace[1].pcmux), 1);
    chk("brne_z0_pcwe", int'(trace[1].pcwe), 1);
    run_instr(fld(20), 2'd0, 2'd0, 4'b0001, 0, 0);
    chk("brne_z1_len", trace.size(), 2);
    chk("brne_z1_mux", int'(trace[1].pcmux), 0);
    chk("brne_z1_pcwe", int'(trace[1].pcwe), 1);

    // BRG taken (Z=0, f1=f2=1), BRGE not taken (f1!=f2)
    run_instr(fld(21), 2'd0, 2'd0, 4'b0110, 0, 0);
    chk("brg_take", int'(trace[1].pcmux), 1);
    run_instr(fld(22), 2'd0, 2'd0, 4'b0010, 0, 0);
    chk("brge_not", int'(trace[1].pcmux), 0);

    // LOAD, ready on third MEM cycle
    run_instr(fld(11), 2'd3, 2'd1, 4'b0000, 3, 0);
    chk("load_len", trace.size(), 6);
    chk("load_rd_cycles", count_field(1), 3);
    chk("load_wb_state", int'(trace[5].st), 3);
    chk("load_wb_mux", int'(trace[5].wbm), 1);
    chk("load_pcwe_once", count_field(0), 1);

    // STORE, memory never ready
    run_instr(fld(13), 2'd2, 2'd1, 4'b0000, 0, 0);
    chk("store_len", trace.size(), 17);
    chk("store_fault", int'(trace[16].fault), 1);
    chk("store_fault_pcwe", int'(trace[16].pcwe), 1);
    chk("store_wr_cycles", count_field(2), 15);
    chk("store_after_we", int'(post.dwe), 0);

    // multi-hot op field
    run_instr(23'h000003, 2'd1, 2'd1, 4'b0000, 0, 0);
    chk("illegal_len", trace.size(), 2);
    chk("illegal_pulse", int'(trace[1].ill), 1);
    chk("illegal_opi", int'(trace[1].opi), 0);

    // reset during second MEM cycle of INPUTD
    run_instr(fld(3), 2'd1, 2'd2, 4'b0000, 0, 2);
    chk("rst_len", trace.size(), 4);
    chk("rst_post_ready", int'(post.rdy), 1);
    chk("rst_post_state", int'(post.st), 0);
    chk("rst_post_dwe", int'(post.dwe), 0);

    // every op index through the model
    for (int op = 0; op < 23; op++) begin
      run_instr(fld(op), 2'(op % 4), 2'((op + 1) % 4), 4'(op), 1 + (op % 3), 0);
      chk("sweep_pcwe_once", count_field(0), 1);
    end

    @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter REG_SEL_W, default 2, meaning register-select width (2**REG_SEL_W registers).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM cycles spent waiting for dmem_ready (range 1..255).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 instr_valid  in  1  opcode valid; instr_ready  out  1  unit can accept an instruction.
REQ-005 opcode  in  23+2*REG_SEL_W  bits[22:0] one-hot op field, next REG_SEL_W bits y, top REG_SEL_W bits x.
REQ-006 flags  in  4  ALU flags: [0]=Z, [1], [2] used by signed compares.
REQ-007 dmem_ready  in  1  data-memory access complete.
REQ-008 Control outputs, all 1 bit unless stated: imem_we, pc_mux, pc_we, reg_port0_sel/reg_port1_sel/reg_write_sel [REG_SEL_W], reg_write_en, alu_src_mux, alu_select [2], flag_write_en, alu_result_mux, dmem_input_mux, dmem_write_en, dmem_read_en, reg_writeback_mux.
REQ-009 Status outputs: opi_o [5] decoded op index; illegal_op 1 (one-cycle pulse); mem_fault 1 (one-cycle pulse); state_o [3] current state.

Function
REQ-010 Op index SHALL be 0 when the op field is all-zero, k+1 when only bit k is set, and illegal otherwise (illegal is decoded as NOOP).
REQ-011 Index map SHALL be: 0 NOOP, 1 INPUTC, 2 INPUTCF, 3 INPUTD, 4 INPUTDF, 5 MOVE, 6 LOADI, 7 ADD, 8 ADDI, 9 SUB, 10 SUBI, 11 LOAD, 12 LOADF, 13 STORE, 14 STOREF, 15 SHIFTL, 16 SHIFTR, 17 CMP, 18 JUMP, 19 BRE, 20 BRNE, 21 BRG, 22 BRGE.
REQ-012 States SHALL be IDLE=0, EXEC=1, MEM=2, WB=3.
REQ-013 instr_ready SHALL equal (state==IDLE); a handshake (instr_valid & instr_ready) SHALL register opcode and opi and move to EXEC.
REQ-014 illegal_op SHALL pulse in the cycle after a handshake of a multi-hot op field.
REQ-015 Port selects, alu_select, alu_src_mux, alu_result_mux, dmem_input_mux and reg_writeback_mux SHALL be decoded from the registered opcode and held constant from EXEC until return to IDLE; they SHALL be 0 in IDLE.
REQ-016 Selects: ADD/SUB/CMP port0=x, port1=y; ADDI/SUBI/SHIFTL/SHIFTR/INPUTCF/INPUTDF port0=x; MOVE/LOADF/STOREF port0=y; STORE/STOREF port1=x; write_sel=x for all register writers.
REQ-017 alu_select SHALL be 10 for ADD/ADDI/MOVE/LOADF/STOREF/INPUTCF/INPUTDF, 11 for SUB/SUBI/CMP, 01 for SHIFTR, and 00 otherwise.
REQ-018 alu_src_mux SHALL be 1 for immediate/offset ops (ADDI, SUBI, LOADF, STOREF, INPUTCF, INPUTDF).
REQ-019 alu_result_mux SHALL be 1 for INPUTC, INPUTD, LOADI and LOAD.
REQ-020 dmem_input_mux SHALL be 1 for INPUTD/INPUTDF; reg_writeback_mux SHALL be 1 for LOAD/LOADF.
REQ-021 EXEC, one cycle, SHALL pulse flag_write_en for ADD/ADDI/SUB/SUBI/SHIFTL/SHIFTR/CMP and pulse imem_we for INPUTC/INPUTCF.
REQ-022 EXEC SHALL drive pc_mux from the flags sampled that cycle: JUMP 1; BRE Z; BRNE ~Z; BRG ~Z & (f1 XNOR f2); BRGE f1 XNOR f2; otherwise 0.
REQ-023 From EXEC, memory ops (INPUTD, INPUTDF, LOAD, LOADF, STORE, STOREF) SHALL go to MEM; MOVE, LOADI, ADD, ADDI, SUB, SUBI, SHIFTL and SHIFTR SHALL go to WB; all others SHALL retire to IDLE with pc_we=1 in EXEC.
REQ-024 In MEM, dmem_write_en (stores, INPUTD*) or dmem_read_en (LOAD*) SHALL be held until the cycle dmem_ready=1 is sampled.
REQ-025 On that cycle, loads SHALL go to WB; other MEM ops SHALL retire with pc_we=1.
REQ-026 A MEM wait counter SHALL clear on MEM entry; if dmem_ready stays low for MEM_TIMEOUT cycles, mem_fault SHALL pulse, pc_we SHALL be 1 (skip the instruction), and the state SHALL return to IDLE with no register write.
REQ-027 WB SHALL last one cycle, with reg_write_en=1 and pc_we=1, then return to IDLE.
REQ-028 pc_we SHALL be 1 in exactly one cycle per instruction; pc_mux SHALL be 0 outside EXEC.
REQ-029 dmem_ready outside MEM SHALL be ignored.

Reset
REQ-030 When rst=1 at a clock edge, state SHALL become IDLE, the wait counter 0, and all outputs 0 except instr_ready=1, regardless of state (MEM waits are aborted with no pc_we).

Verification
REQ-031 Test ADD, x=1, y=2 -> EXEC: flag_write_en=1; WB: reg_write_en=1, write_sel=1, pc_we=1; 3 cycles handshake-to-ready.
REQ-032 Test BRNE with Z=0 and then Z=1 -> EXEC pc_mux=1/pc_we=1, then pc_mux=0/pc_we=1; 2 cycles each.
REQ-033 Test LOAD with dmem_ready after 3 MEM cycles -> dmem_read_en high 3 cycles, then WB with reg_writeback_mux=1.
REQ-034 Test STORE with dmem_ready never asserted, MEM_TIMEOUT=15 -> mem_fault pulse at MEM cycle 15, pc_we=1, IDLE, no dmem_write_en afterwards.
REQ-035 Test op field 0x000003 -> illegal_op pulse, opi_o=0, retire in 2 cycles.
REQ-036 Test rst asserted in MEM cycle 2 -> next cycle IDLE, all outputs 0 except instr_ready=1.
